// File: rtl/miriscv_mem_pkg.sv
// Shared types and constants for the data memory responder.
package miriscv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } mem_resp_state_e;

    // Width of the latency counter; covers LATENCY values 1..15.
    localparam int MEM_LAT_W = 4;

endpackage

// File: rtl/miriscv_data_mem_responder_if.sv
// Core data memory bus: request/store side from the core, response side back.
interface miriscv_data_mem_responder_if #(
    parameter int XLEN = 32
);

    logic              data_req_i;
    logic              data_we_i;
    logic [XLEN/8-1:0] data_be_i;
    logic [XLEN-1:0]   data_addr_i;
    logic [XLEN-1:0]   data_wdata_i;
    logic              data_rvalid_o;
    logic [XLEN-1:0]   data_rdata_o;

    modport master (
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  data_rvalid_o, data_rdata_o
    );

    modport slave (
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output data_rvalid_o, data_rdata_o
    );

endinterface

// File: rtl/miriscv_sram_be.sv
// Byte-writable word array: one synchronous write port, one combinational read port.
module miriscv_sram_be #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 4096
) (
    input  logic                           clk_i,
    input  logic                           we,
    input  logic [XLEN/8-1:0]              be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] wr_idx,
    input  logic [XLEN-1:0]                wdata,
    input  logic [$clog2(DEPTH_WORDS)-1:0] rd_idx,
    output logic [XLEN-1:0]                rdata
);

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    // Update only the byte lanes whose enable is set.
    always_ff @(posedge clk_i) begin
        if (we) begin
            for (int b = 0; b < XLEN/8; b++) begin
                if (be[b]) begin
                    mem[wr_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[rd_idx];

endmodule

// File: rtl/miriscv_data_mem_responder.sv
// Data RAM responder: accepts one core access at a time and answers after a
// fixed latency, extended by stall_i. Stores commit together with the response.
module miriscv_data_mem_responder
    import miriscv_mem_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              DEPTH_WORDS = 4096,
    parameter logic [XLEN-1:0] BASE_ADDR   = '0,
    parameter int              LATENCY     = 1
) (
    input  logic clk_i,
    input  logic arstn_i,
    input  logic stall_i,
    output logic oor_o,
    miriscv_data_mem_responder_if.slave bus
);

    localparam int                   IDX_W    = $clog2(DEPTH_WORDS);
    localparam int                   BE_W     = XLEN/8;
    localparam logic [XLEN:0]        SPAN     = (XLEN+1)'(DEPTH_WORDS) << 2;
    localparam logic [MEM_LAT_W-1:0] CNT_INIT = MEM_LAT_W'(LATENCY - 1);

    mem_resp_state_e      state, state_nxt;
    logic [MEM_LAT_W-1:0] cnt, cnt_nxt;
    logic                 accept;
    logic                 respond;

    logic [XLEN-1:0]      addr_q;
    logic                 we_q;
    logic [BE_W-1:0]      be_q;
    logic [XLEN-1:0]      wdata_q;

    logic [XLEN-1:0]      offset;
    logic                 in_range;
    logic [IDX_W-1:0]     idx;
    logic [XLEN-1:0]      sram_rdata;
    logic [XLEN-1:0]      load_word;
    logic [XLEN-1:0]      rdata_q;
    logic                 oor_q;

    // Next-state, counter and handshake decode; RESP ignores data_req_i.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        respond   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.data_req_i) begin
                    accept    = 1'b1;
                    cnt_nxt   = CNT_INIT;
                    state_nxt = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (!stall_i) begin
                    cnt_nxt = cnt - 1'b1;
                    if (cnt == MEM_LAT_W'(1)) begin
                        state_nxt = RESP;
                    end
                end
            end
            RESP: begin
                if (!stall_i) begin
                    respond   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and latency counter registers; reset abandons any pending access.
    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Capture the request on acceptance so the core may change its bus afterwards.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            addr_q  <= bus.data_addr_i;
            we_q    <= bus.data_we_i;
            be_q    <= bus.data_be_i;
            wdata_q <= bus.data_wdata_i;
        end
    end

    // Offset from the base; wrap-around below BASE_ADDR lands out of range too.
    assign offset   = addr_q - BASE_ADDR;
    assign in_range = {1'b0, offset} < SPAN;
    assign idx      = offset[IDX_W+1:2];

    miriscv_sram_be #(
        .XLEN        (XLEN),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_sram (
        .clk_i  (clk_i),
        .we     (respond && we_q && in_range),
        .be     (be_q),
        .wr_idx (idx),
        .wdata  (wdata_q),
        .rd_idx (idx),
        .rdata  (sram_rdata)
    );

    assign load_word = in_range ? sram_rdata : '0;

    // Hold the last load data between responses and latch the sticky range flag.
    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            rdata_q <= '0;
            oor_q   <= 1'b0;
        end else if (respond) begin
            if (!we_q) begin
                rdata_q <= load_word;
            end
            if (!in_range) begin
                oor_q <= 1'b1;
            end
        end
    end

    assign bus.data_rvalid_o = respond;
    assign bus.data_rdata_o  = (respond && !we_q) ? load_word : rdata_q;
    assign oor_o             = oor_q;

endmodule
